lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 142 ++++++++++++++
 tb/tb_lsu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: turns M-stage loads/stores into single valid/ready bus transactions and stalls F..M until the response.
// Latency: request in IDLE, >=1 WAIT cycle, one DONE cycle with busy_M low; backpressure via bus_req_ready holds REQ.
module lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mm_re_M,
   input  logic        mm_we_M,
   input  logic [2:0]  funct3_M,
   input  logic [31:0] addr_M,
   input  logic [31:0] wdata_M,
   output logic        busy_M,
   output logic [31:0] rdata_M,
   output logic        misaligned_M,
   output logic        err_M,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_req_we,
   output logic [31:0] bus_req_addr,
   output logic [31:0] bus_req_wdata,
   output logic [3:0]  bus_req_wstrb,
   input  logic        bus_resp_valid,
   input  logic [31:0] bus_resp_rdata,
   input  logic        bus_resp_err
);

   localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;
   logic           mem_op;
   logic           req_vld;
   logic           timeout_hit;
   logic [31:0]    lane_dat;
   logic [31:0]    load_dat;
   logic           sext;

   always_comb begin
      misaligned_M = 1'b0;
      if (mm_re_M | mm_we_M) begin
         if (funct3_M[1:0] == 2'b01 && addr_M[0])
            misaligned_M = 1'b1;
         else if (funct3_M[1:0] == 2'b10 && addr_M[1:0] != 2'b00)
            misaligned_M = 1'b1;
      end
   end

   assign mem_op = (mm_re_M | mm_we_M) & ~misaligned_M;
   assign busy_M = mem_op & (state_q != DONE);

   // The pipeline is frozen while busy_M is high, so the M-stage inputs
   // themselves keep every request field stable through REQ.
   assign bus_req_we    = mm_we_M;
   assign bus_req_addr  = {addr_M[31:2], 2'b00};
   assign bus_req_wdata = wdata_M << {addr_M[1:0], 3'b000};
   always_comb begin
      bus_req_wstrb = 4'b0000;
      if (mm_we_M) begin
         case (funct3_M[1:0])
            2'b00:   bus_req_wstrb = 4'b0001 << addr_M[1:0];
            2'b01:   bus_req_wstrb = 4'b0011 << addr_M[1:0];
            default: bus_req_wstrb = 4'b1111;
         endcase
      end
   end
   assign bus_req_valid = req_vld & rst_n;

   assign lane_dat = bus_resp_rdata >> {addr_M[1:0], 3'b000};
   assign sext     = ~funct3_M[2];
   always_comb begin
      case (funct3_M[1:0])
         2'b00:   load_dat = {{24{sext & lane_dat[7]}}, lane_dat[7:0]};
         2'b01:   load_dat = {{16{sext & lane_dat[15]}}, lane_dat[15:0]};
         default: load_dat = bus_resp_rdata;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TO_M1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      req_vld = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               req_vld = 1'b1;
               cnt_d   = '0;
               state_d = bus_req_ready ? WAIT : REQ;
            end
         end
         REQ: begin
            req_vld = 1'b1;
            if (bus_req_ready) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // A response landing in the timeout cycle still wins.
            if (bus_resp_valid) begin
               state_d = DONE;
               err_d   = bus_resp_err;
               if (mm_re_M)
                  rdata_d = load_dat;
            end else if (timeout_hit) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign rdata_M = rdata_q;
   assign err_M   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, misalignment, timeout, reset abort and back-to-back traffic.
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mm_re_M = 1'b0, mm_we_M = 1'b0;
   logic [2:0]  funct3_M = 3'b000;
   logic [31:0] addr_M = '0, wdata_M = '0;
   logic        busy_M, misaligned_M, err_M;
   logic [31:0] rdata_M;
   logic        bus_req_valid, bus_req_we;
   logic        bus_req_ready = 1'b0;
   logic [31:0] bus_req_addr, bus_req_wdata;
   logic [3:0]  bus_req_wstrb;
   logic        bus_resp_valid = 1'b0, bus_resp_err = 1'b0;
   logic [31:0] bus_resp_rdata = '0;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_rd = '0;

   lsu #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .mm_re_M(mm_re_M), .mm_we_M(mm_we_M), .funct3_M(funct3_M),
      .addr_M(addr_M), .wdata_M(wdata_M),
      .busy_M(busy_M), .rdata_M(rdata_M), .misaligned_M(misaligned_M), .err_M(err_M),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
      .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mm_re_M = 1'b0; mm_we_M = 1'b0; bus_req_ready = 1'b0;
      bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (busy_M !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_M); end
      checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_req_valid); end
      checks++; if (rdata_M !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_M); end
      checks++; if (err_M !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_M); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_lb();
      mm_re_M = 1'b1; funct3_M = 3'b000; addr_M = 32'h1003; bus_req_ready = 1'b1;
      #1;
      checks++; if (busy_M !== 1'b1 || bus_req_valid !== 1'b1) begin errors++; $display("FAIL lb_idle: busy=%b valid=%b want 1 1", busy_M, bus_req_valid); end
      checks++; if (bus_req_addr !== 32'h1000 || bus_req_wstrb !== 4'b0000) begin errors++; $display("FAIL lb_fields: addr=%h wstrb=%b want 00001000 0000", bus_req_addr, bus_req_wstrb); end
      tick();
      bus_req_ready = 1'b0;
      #1;
      checks++; if (busy_M !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL lb_wait1: busy=%b valid=%b want 1 0", busy_M, bus_req_valid); end
      tick();
      bus_resp_valid = 1'b1; bus_resp_rdata = 32'h80FF_FF12;
      #1;
      checks++; if (busy_M !== 1'b1) begin errors++; $display("FAIL lb_wait2: busy=%b want 1", busy_M); end
      tick();
      bus_resp_valid = 1'b0;
      exp_rd = 32'hFFFF_FF80;
      #1;
      checks++; if (busy_M !== 1'b0) begin errors++; $display("FAIL lb_done_busy: got %b want 0", busy_M); end
      checks++; if (rdata_M !== exp_rd) begin errors++; $display("FAIL lb_rdata: got %h want %h", rdata_M, exp_rd); end
      tick();
      idle_inputs();
      #1;
      checks++; if (busy_M !== 1'b0 || rdata_M !== exp_rd) begin errors++; $display("FAIL lb_after: busy=%b rdata=%h want 0 %h", busy_M, rdata_M, exp_rd); end
   endtask

   task automatic test_sh_backpressure();
      mm_we_M = 1'b1; funct3_M = 3'b001; addr_M = 32'h2002; wdata_M = 32'h0000_ABCD;
      for (int i = 0; i < 5; i++) begin
         bus_req_ready = (i == 4);
         #1;
         checks++;
         if (bus_req_valid !== 1'b1 || busy_M !== 1'b1 || bus_req_we !== 1'b1 || bus_req_addr !== 32'h2000 ||
             bus_req_wstrb !== 4'b1100 || bus_req_wdata !== 32'hABCD_0000) begin
            errors++;
            $display("FAIL sh_req_c%0d: valid=%b busy=%b we=%b addr=%h wstrb=%b wdata=%h want 1 1 1 00002000 1100 abcd0000",
                     i, bus_req_valid, busy_M, bus_req_we, bus_req_addr, bus_req_wstrb, bus_req_wdata);
         end
         tick();
      end
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h5555_5555;
      #1;
      checks++; if (bus_req_valid !== 1'b0 || busy_M !== 1'b1) begin errors++; $display("FAIL sh_wait: valid=%b busy=%b want 0 1", bus_req_valid, busy_M); end
      tick();
      bus_resp_valid = 1'b0;
      #1;
      checks++; if (busy_M !== 1'b0 || err_M !== 1'b0 || rdata_M !== exp_rd) begin errors++; $display("FAIL sh_done: busy=%b err=%b rdata=%h want 0 0 %h", busy_M, err_M, rdata_M, exp_rd); end
      tick();
      idle_inputs();
   endtask

   task automatic test_misaligned();
      mm_re_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h3001; bus_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (misaligned_M !== 1'b1 || busy_M !== 1'b0 || bus_req_valid !== 1'b0 || rdata_M !== exp_rd) begin
            errors++;
            $display("FAIL lw_misaligned_c%0d: mis=%b busy=%b valid=%b rdata=%h want 1 0 0 %h", i, misaligned_M, busy_M, bus_req_valid, rdata_M, exp_rd);
         end
         tick();
      end
      funct3_M = 3'b101; addr_M = 32'h3003;
      #1;
      checks++; if (misaligned_M !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL lhu_misaligned: mis=%b valid=%b want 1 0", misaligned_M, bus_req_valid); end
      funct3_M = 3'b000;
      #1;
      checks++; if (misaligned_M !== 1'b0) begin errors++; $display("FAIL lb_odd_aligned: mis=%b want 0", misaligned_M); end
      idle_inputs();
      tick();
   endtask

   task automatic test_timeout();
      mm_re_M = 1'b1; funct3_M = 3'b101; addr_M = 32'h4002; bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (busy_M !== 1'b1) begin errors++; $display("FAIL to_wait_c%0d: busy=%b want 1", i, busy_M); end
         tick();
      end
      #1;
      checks++; if (busy_M !== 1'b0 || err_M !== 1'b1 || rdata_M !== exp_rd) begin errors++; $display("FAIL to_done: busy=%b err=%b rdata=%h want 0 1 %h", busy_M, err_M, rdata_M, exp_rd); end
      tick();
      idle_inputs();
      #1;
      checks++; if (err_M !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", err_M); end
      bus_resp_valid = 1'b1; bus_resp_rdata = 32'h1234_5678;
      tick();
      bus_resp_valid = 1'b0;
      #1;
      checks++; if (rdata_M !== exp_rd || err_M !== 1'b0 || busy_M !== 1'b0) begin errors++; $display("FAIL to_late_resp: rdata=%h err=%b busy=%b want %h 0 0", rdata_M, err_M, busy_M, exp_rd); end
      tick();
   endtask

   task automatic test_resp_at_timeout();
      mm_re_M = 1'b1; funct3_M = 3'b001; addr_M = 32'h9002; bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      tick(); tick(); tick();
      bus_resp_valid = 1'b1; bus_resp_rdata = 32'h8001_1234; bus_resp_err = 1'b0;
      tick();
      bus_resp_valid = 1'b0;
      exp_rd = 32'hFFFF_8001;
      #1;
      checks++; if (err_M !== 1'b0 || rdata_M !== exp_rd || busy_M !== 1'b0) begin errors++; $display("FAIL race_done: err=%b rdata=%h busy=%b want 0 %h 0", err_M, rdata_M, busy_M, exp_rd); end
      tick();
      idle_inputs();
   endtask

   task automatic test_sb_err();
      mm_we_M = 1'b1; funct3_M = 3'b000; addr_M = 32'h8001; wdata_M = 32'h0000_005A; bus_req_ready = 1'b1;
      #1;
      checks++; if (bus_req_wstrb !== 4'b0010 || bus_req_wdata !== 32'h0000_5A00) begin errors++; $display("FAIL sb_fields: wstrb=%b wdata=%h want 0010 00005a00", bus_req_wstrb, bus_req_wdata); end
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_err = 1'b1;
      tick();
      bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
      #1;
      checks++; if (err_M !== 1'b1 || busy_M !== 1'b0 || rdata_M !== exp_rd) begin errors++; $display("FAIL sb_err_done: err=%b busy=%b rdata=%h want 1 0 %h", err_M, busy_M, rdata_M, exp_rd); end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      mm_re_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h5000; bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if (rdata_M !== 32'h0 || err_M !== 1'b0 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid: rdata=%h err=%b valid=%b want 0 0 0", rdata_M, err_M, bus_req_valid); end
      tick();
      idle_inputs();
      rst_n = 1'b1;
      exp_rd = 32'h0;
      #1;
      bus_resp_valid = 1'b1; bus_resp_rdata = 32'hFFFF_FFFF; bus_resp_err = 1'b1;
      tick();
      bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
      #1;
      checks++; if (busy_M !== 1'b0 || err_M !== 1'b0 || rdata_M !== 32'h0) begin errors++; $display("FAIL rst_drop: busy=%b err=%b rdata=%h want 0 0 0", busy_M, err_M, rdata_M); end
      tick();
      checks++; if (err_M !== 1'b0) begin errors++; $display("FAIL rst_no_done: err=%b want 0", err_M); end
      mm_re_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h6000;
      #1;
      checks++; if (busy_M !== 1'b1 || bus_req_valid !== 1'b1) begin errors++; $display("FAIL rst_new_idle: busy=%b valid=%b want 1 1", busy_M, bus_req_valid); end
      tick();
      checks++; if (busy_M !== 1'b1 || bus_req_valid !== 1'b1) begin errors++; $display("FAIL rst_new_req: busy=%b valid=%b want 1 1", busy_M, bus_req_valid); end
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFE_F00D;
      tick();
      bus_resp_valid = 1'b0;
      exp_rd = 32'hCAFE_F00D;
      #1;
      checks++; if (rdata_M !== exp_rd || busy_M !== 1'b0) begin errors++; $display("FAIL rst_new_lw: rdata=%h busy=%b want %h 0", rdata_M, busy_M, exp_rd); end
      tick();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      mm_re_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h7000; bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h1122_3344;
      #1;
      checks++; if (busy_M !== 1'b1) begin errors++; $display("FAIL b2b_wait: busy=%b want 1", busy_M); end
      tick();
      bus_resp_valid = 1'b0;
      exp_rd = 32'h1122_3344;
      #1;
      checks++; if (busy_M !== 1'b0 || rdata_M !== exp_rd) begin errors++; $display("FAIL b2b_done: busy=%b rdata=%h want 0 %h", busy_M, rdata_M, exp_rd); end
      tick();
      mm_re_M = 1'b0; mm_we_M = 1'b1; addr_M = 32'h7004; wdata_M = 32'hDEAD_BEEF; bus_req_ready = 1'b1;
      #1;
      checks++;
      if (busy_M !== 1'b1 || bus_req_valid !== 1'b1 || bus_req_we !== 1'b1 || bus_req_wstrb !== 4'b1111 ||
          bus_req_addr !== 32'h7004 || bus_req_wdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL b2b_sw_issue: busy=%b valid=%b we=%b wstrb=%b addr=%h wdata=%h want 1 1 1 1111 00007004 deadbeef",
                  busy_M, bus_req_valid, bus_req_we, bus_req_wstrb, bus_req_addr, bus_req_wdata);
      end
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
      tick();
      bus_resp_valid = 1'b0;
      #1;
      checks++; if (busy_M !== 1'b0 || rdata_M !== exp_rd) begin errors++; $display("FAIL b2b_sw_done: busy=%b rdata=%h want 0 %h", busy_M, rdata_M, exp_rd); end
      tick();
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh_backpressure();
      test_misaligned();
      test_timeout();
      test_resp_at_timeout();
      test_sb_err();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
